// File: rtl/elc3_control.sv
// eLC-3 control unit: instruction sequencing FSM driving every load, gate,
// mux select, ALU and memory-control input of the Datapath. Outputs are
// registered and decoded from the state being entered, so each output
// pattern lines up exactly with the state register.
module elc3_control #(
    parameter int MEM_CYCLES = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [4:0] IR_15_11,
    input  logic       IR_5,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_REG,
    output logic       LD_CC,
    output logic       LD_PC,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] PCMUX,
    output logic [1:0] DRMUX,
    output logic [1:0] SR1MUX,
    output logic [1:0] SR2MUX,
    output logic [1:0] MARMUX,
    output logic [1:0] ALUK,
    output logic       MIO_EN,
    output logic       R_W,
    output logic       Halted,
    output logic       Paused
);

    typedef enum logic [4:0] {
        S_HALTED, S_F1, S_F2, S_F3, S_DEC,
        S_ADD, S_AND, S_NOT,
        S_BR0, S_BR1, S_JMP,
        S_JS0, S_JS1_PC, S_JS1_BASE,
        S_A0_PC, S_A0_BASE, S_M_RD, S_WB, S_S1, S_M_WR,
        S_LEA, S_P0, S_P1
    } state_t;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_reg, ld_cc, ld_pc;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic       addr1mux;
        logic [1:0] addr2mux, pcmux, drmux, sr1mux, sr2mux, marmux, aluk;
        logic       mio_en, r_w, halted, paused;
    } ctrl_t;

    // Wait counter just wide enough to reach MEM_CYCLES-1; it never wraps.
    localparam int CNT_W = (MEM_CYCLES > 1) ? $clog2(MEM_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_CYCLES - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             run_q;
    ctrl_t            ctrl;
    logic [3:0]       opcode;

    assign opcode = IR_15_11[4:1];

    // Output pattern for a state; ir5 only matters for ADD/AND, last only
    // for memory reads (LD_MDR on the final access cycle).
    function automatic ctrl_t decode(input state_t s, input logic ir5, input logic last);
        ctrl_t c;
        c = '0;
        case (s)
            S_HALTED: c.halted = 1'b1;
            S_F1: begin
                c.gate_pc = 1'b1;
                c.ld_mar  = 1'b1;
                c.ld_pc   = 1'b1;
            end
            S_F2, S_M_RD: begin
                c.mio_en = 1'b1;
                c.ld_mdr = last;
            end
            S_F3: begin
                c.gate_mdr = 1'b1;
                c.ld_ir    = 1'b1;
            end
            S_DEC: c.ld_ben = 1'b1;
            S_ADD, S_AND, S_NOT: begin
                c.sr1mux   = 2'b01;
                c.gate_alu = 1'b1;
                c.ld_reg   = 1'b1;
                c.ld_cc    = 1'b1;
                c.aluk     = (s == S_ADD) ? 2'b00 : (s == S_AND) ? 2'b01 : 2'b10;
                c.sr2mux   = (s == S_NOT) ? 2'b00 : {1'b0, ir5};
            end
            S_BR1: begin
                c.addr2mux = 2'b10;
                c.pcmux    = 2'b10;
                c.ld_pc    = 1'b1;
            end
            S_JMP, S_JS1_BASE: begin
                c.sr1mux   = 2'b01;
                c.addr1mux = 1'b1;
                c.pcmux    = 2'b10;
                c.ld_pc    = 1'b1;
            end
            S_JS0: begin
                c.gate_pc = 1'b1;
                c.drmux   = 2'b01;
                c.ld_reg  = 1'b1;
            end
            S_JS1_PC: begin
                c.addr2mux = 2'b11;
                c.pcmux    = 2'b10;
                c.ld_pc    = 1'b1;
            end
            S_A0_PC: begin
                c.gate_marmux = 1'b1;
                c.ld_mar      = 1'b1;
                c.addr2mux    = 2'b10;
            end
            S_A0_BASE: begin
                c.gate_marmux = 1'b1;
                c.ld_mar      = 1'b1;
                c.addr1mux    = 1'b1;
                c.sr1mux      = 2'b01;
                c.addr2mux    = 2'b01;
            end
            S_WB: begin
                c.gate_mdr = 1'b1;
                c.ld_reg   = 1'b1;
                c.ld_cc    = 1'b1;
            end
            S_S1: begin
                c.aluk     = 2'b11;
                c.gate_alu = 1'b1;
                c.ld_mdr   = 1'b1;
            end
            S_M_WR: begin
                c.mio_en = 1'b1;
                c.r_w    = 1'b1;
            end
            S_LEA: begin
                c.addr2mux    = 2'b10;
                c.gate_marmux = 1'b1;
                c.ld_reg      = 1'b1;
                c.ld_cc       = 1'b1;
            end
            S_P0, S_P1: c.paused = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    // Next-state and wait-counter logic.
    always_comb begin
        // NOTE: defaults first so every path assigns both targets; a missed
        // branch would otherwise infer a latch.
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            S_HALTED: if (Run && !run_q) state_nx = S_F1;
            S_F1:     state_nx = S_F2;
            S_F2, S_M_RD, S_M_WR: begin
                if (cnt == CNT_LAST) begin
                    cnt_nx   = '0;
                    state_nx = (state == S_F2) ? S_F3 : (state == S_M_RD) ? S_WB : S_F1;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            S_F3:     state_nx = S_DEC;
            S_DEC: begin
                case (opcode)
                    4'b0001: state_nx = S_ADD;
                    4'b0101: state_nx = S_AND;
                    4'b1001: state_nx = S_NOT;
                    4'b0000: state_nx = S_BR0;
                    4'b1100: state_nx = S_JMP;
                    4'b0100: state_nx = S_JS0;
                    4'b0010, 4'b0011: state_nx = S_A0_PC;
                    4'b0110, 4'b0111: state_nx = S_A0_BASE;
                    4'b1110: state_nx = S_LEA;
                    4'b1101: state_nx = S_P0;
                    4'b1111: state_nx = S_HALTED;
                    default: state_nx = S_F1;
                endcase
            end
            S_BR0:    state_nx = BEN ? S_BR1 : S_F1;
            S_JS0:    state_nx = IR_15_11[0] ? S_JS1_PC : S_JS1_BASE;
            // Opcode bit 0 separates stores (0011/0111) from loads.
            S_A0_PC, S_A0_BASE: state_nx = opcode[0] ? S_S1 : S_M_RD;
            S_S1:     state_nx = S_M_WR;
            S_P0:     if (Continue) state_nx = S_P1;
            S_P1:     if (!Continue) state_nx = S_F1;
            default:  state_nx = S_F1;
        endcase
    end

    // State, counter, Run edge detector and registered outputs.
    always_ff @(posedge Clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (!Reset) begin
            state <= S_HALTED;
            cnt   <= '0;
            run_q <= 1'b0;
            ctrl  <= decode(S_HALTED, 1'b0, 1'b0);
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            run_q <= Run;
            ctrl  <= decode(state_nx, IR_5, cnt_nx == CNT_LAST);
        end
    end

    assign LD_MAR     = ctrl.ld_mar;
    assign LD_MDR     = ctrl.ld_mdr;
    assign LD_IR      = ctrl.ld_ir;
    assign LD_BEN     = ctrl.ld_ben;
    assign LD_REG     = ctrl.ld_reg;
    assign LD_CC      = ctrl.ld_cc;
    assign LD_PC      = ctrl.ld_pc;
    assign GatePC     = ctrl.gate_pc;
    assign GateMDR    = ctrl.gate_mdr;
    assign GateALU    = ctrl.gate_alu;
    assign GateMARMUX = ctrl.gate_marmux;
    assign ADDR1MUX   = ctrl.addr1mux;
    assign ADDR2MUX   = ctrl.addr2mux;
    assign PCMUX      = ctrl.pcmux;
    assign DRMUX      = ctrl.drmux;
    assign SR1MUX     = ctrl.sr1mux;
    assign SR2MUX     = ctrl.sr2mux;
    assign MARMUX     = ctrl.marmux;
    assign ALUK       = ctrl.aluk;
    assign MIO_EN     = ctrl.mio_en;
    assign R_W        = ctrl.r_w;
    assign Halted     = ctrl.halted;
    assign Paused     = ctrl.paused;

endmodule
